// File: rtl/stream_pkg.sv
// Shared helpers for pointer-based stream blocks.
package stream_pkg;

  // One extra bit above the index width serves as the wrap bit.
  function automatic int stream_fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// FIFO storage: registered write port, combinational read port, no reset.
module stream_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO; handshake outputs come only from registered pointers,
// so neither side sees a same-cycle combinational path from the other.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   valid_input,
  output logic                                   ready_input,
  input  logic [DATA_WIDTH-1:0]                  data_input,
  output logic                                   valid_output,
  input  logic                                   ready_output,
  output logic [DATA_WIDTH-1:0]                  data_output,
  output logic [stream_fifo_ptr_width(DEPTH)-1:0] count
);

  localparam int PW = stream_fifo_ptr_width(DEPTH);
  localparam int AW = PW - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign ready_input  = !full;
  assign valid_output = !empty;

  assign push = valid_input && ready_input;
  assign pop  = valid_output && ready_output;

  // Pointers are exactly PW bits wide, so natural overflow is the mod 2*DEPTH wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  stream_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_input),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (data_output)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and scoreboard checks for stream_fifo at DEPTH=4, DATA_WIDTH=32.
module tb_stream_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_input = 1'b0;
  logic          ready_input;
  logic [DW-1:0] data_input = '0;
  logic          valid_output;
  logic          ready_output = 1'b0;
  logic [DW-1:0] data_output;
  logic [2:0]    count;

  int checks = 0;
  int failures = 0;

  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_input  (valid_input),
    .ready_input  (ready_input),
    .data_input   (data_input),
    .valid_output (valid_output),
    .ready_output (ready_output),
    .data_output  (data_output),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    int model_cnt;
    int pops;
    int cyc;
    bit exp_push;
    bit exp_pop;

    // Reset held with valid_input asserted
    rst = 1'b0;
    valid_input = 1'b1;
    data_input = 32'h55;
    tick(); tick();
    check_val("rst_ready", ready_input, 1);
    check_val("rst_valid", valid_output, 0);
    check_val("rst_count", count, 0);
    rst = 1'b1;
    tick();
    check_val("first_valid", valid_output, 1);
    check_val("first_data", data_output, 32'h55);
    check_val("first_count", count, 1);
    valid_input = 1'b0;
    ready_output = 1'b1;
    tick();
    check_val("first_drain", valid_output, 0);

    // Fill then drain
    ready_output = 1'b0;
    valid_input = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_input = 32'hA0 + i;
      tick();
    end
    check_val("fill_count", count, 4);
    check_val("fill_ready", ready_input, 0);
    data_input = 32'hA4;
    tick();
    check_val("fifth_count", count, 4);
    check_val("hold_data", data_output, 32'hA0);
    check_val("hold_valid", valid_output, 1);
    valid_input = 1'b0;
    ready_output = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_valid", valid_output, 1);
      check_val("drain_data", data_output, 32'hA0 + i);
      tick();
    end
    check_val("drain_empty", valid_output, 0);
    check_val("drain_count", count, 0);

    // Streaming 0..19
    valid_input = 1'b1;
    ready_output = 1'b1;
    data_input = 0;
    check_val("stream_lat", valid_output, 0);
    tick();
    for (int i = 1; i < 20; i++) begin
      data_input = i;
      check_val("stream_data", data_output, i - 1);
      check_val("stream_count", count, 1);
      tick();
    end
    valid_input = 1'b0;
    check_val("stream_last", data_output, 19);
    tick();
    check_val("stream_empty", valid_output, 0);

    // Full with simultaneous ready
    ready_output = 1'b0;
    valid_input = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_input = 32'hB0 + i;
      tick();
    end
    data_input = 32'hB4;
    ready_output = 1'b1;
    check_val("full_rdy", ready_input, 0);
    tick();
    check_val("full_pop_only", count, 3);
    check_val("full_rdy_after", ready_input, 1);
    tick();
    check_val("full_accept", count, 3);
    valid_input = 1'b0;
    for (int i = 2; i < 5; i++) begin
      check_val("full_order", data_output, 32'hB0 + i);
      tick();
    end
    check_val("full_empty", valid_output, 0);

    // Random valid/ready against a scoreboard
    q.delete();
    model_cnt = 0;
    pops = 0;
    cyc = 0;
    while (pops < 1000 && cyc < 20000) begin
      valid_input = 1'($urandom_range(0, 1));
      ready_output = 1'($urandom_range(0, 1));
      data_input = $urandom;
      #1;
      check_val("rnd_ready", ready_input, model_cnt < DEPTH);
      check_val("rnd_valid", valid_output, model_cnt > 0);
      check_val("rnd_count", count, model_cnt);
      if (model_cnt > 0) check_val("rnd_data", data_output, q[0]);
      exp_push = valid_input && (model_cnt < DEPTH);
      exp_pop = ready_output && (model_cnt > 0);
      tick();
      if (exp_pop) begin
        void'(q.pop_front());
        pops++;
        model_cnt--;
      end
      if (exp_push) begin
        q.push_back(data_input);
        model_cnt++;
      end
      cyc++;
    end
    check_val("rnd_done", pops, 1000);

    // Drain leftovers, then reset mid-stream
    valid_input = 1'b0;
    ready_output = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    ready_output = 1'b0;
    valid_input = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_input = 32'hC0 + i;
      tick();
    end
    valid_input = 1'b0;
    check_val("pre_rst_count", count, 3);
    rst = 1'b0;
    #1;
    check_val("async_valid", valid_output, 0);
    check_val("async_count", count, 0);
    tick();
    rst = 1'b1;
    check_val("post_rst_valid", valid_output, 0);
    valid_input = 1'b1;
    data_input = 32'hD0;
    tick();
    valid_input = 1'b0;
    check_val("post_rst_data", data_output, 32'hD0);
    check_val("post_rst_count", count, 1);
    ready_output = 1'b1;
    tick();
    check_val("post_rst_empty", valid_output, 0);
    check_val("post_rst_count0", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
